// File: rtl/eth_tx_scheduler_pkg.sv
// Shared constants, state encoding and width helper for the Ethernet TX scheduler.
package eth_tx_scheduler_pkg;

  localparam int BYTE_LEN       = 8;
  localparam int ETH_IPG_DIBITS = 48;

  typedef enum logic [1:0] {
    SCHED_IDLE  = 2'd0,
    SCHED_START = 2'd1,
    SCHED_BUSY  = 2'd2,
    SCHED_GAP   = 2'd3
  } sched_state_e;

  // Ceiling log2, never below 1 so degenerate parameters still give a usable register.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/eth_tx_scheduler_if.sv
// Requester and generator side signals of the TX scheduler; master is the scheduler.
interface eth_tx_scheduler_if #(
  parameter int NUM_REQ = 2
);
  import eth_tx_scheduler_pkg::*;

  logic [NUM_REQ-1:0]          req;
  logic [NUM_REQ-1:0]          req_inclk;
  logic [NUM_REQ*BYTE_LEN-1:0] req_in;
  logic [NUM_REQ-1:0]          req_in_done;
  logic [NUM_REQ-1:0]          req_readclk;
  logic [NUM_REQ-1:0]          req_ack;
  logic [NUM_REQ-1:0]          grant;
  logic                        gen_start;
  logic                        gen_inclk;
  logic [BYTE_LEN-1:0]         gen_in;
  logic                        gen_in_done;
  logic                        gen_upstream_readclk;
  logic                        gen_done;
  logic                        busy;

  modport master (
    input  req, req_inclk, req_in, req_in_done, gen_upstream_readclk, gen_done,
    output req_readclk, req_ack, grant, gen_start, gen_inclk, gen_in, gen_in_done, busy
  );

  modport slave (
    output req, req_inclk, req_in, req_in_done, gen_upstream_readclk, gen_done,
    input  req_readclk, req_ack, grant, gen_start, gen_inclk, gen_in, gen_in_done, busy
  );

endinterface

// File: rtl/eth_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set req bit after ptr, wrapping modulo NUM_REQ.
module eth_tx_scheduler_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   idx
);

  always_comb begin
    int  j;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/eth_tx_scheduler.sv
// Shares one eth_frame_generator among NUM_REQ sources with round-robin grant and IPG spacing.
// Define ETH_TX_SCHED_STATS_EN to add frame_cnt / max_wait statistics outputs.
//
// state | meaning
// IDLE  | waiting for any req; arbitrates on the clock edge
// START | one-cycle gen_start to the generator
// BUSY  | frame in flight; payload muxed from the granted source
// GAP   | inter-packet gap down-count before the next arbitration
module eth_tx_scheduler
  import eth_tx_scheduler_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int IPG_CYCLES = ETH_IPG_DIBITS
) (
  input  logic                clk,
  input  logic                rst,
  eth_tx_scheduler_if.master  bus
`ifdef ETH_TX_SCHED_STATS_EN
  ,
  output logic [31:0]         frame_cnt,
  output logic [15:0]         max_wait
`endif
);

  localparam int PTR_W = clog2(NUM_REQ);
  localparam int GAP_W = clog2(IPG_CYCLES + 1);

  sched_state_e        state;
  logic [NUM_REQ-1:0]  grant_q;
  logic                gen_start_q;
  logic [PTR_W-1:0]    rr_ptr;
  logic [GAP_W-1:0]    gap_cnt;
  logic [NUM_REQ-1:0]  arb_gnt;
  logic [PTR_W-1:0]    arb_idx;
  logic                done_ok;
  logic                mux_inclk;
  logic [BYTE_LEN-1:0] mux_in;
  logic                mux_done;

  eth_tx_scheduler_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req (bus.req),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign done_ok = (state == SCHED_BUSY) && bus.gen_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SCHED_IDLE;
      grant_q     <= '0;
      gen_start_q <= 1'b0;
      rr_ptr      <= '0;
      gap_cnt     <= '0;
    end else begin
      gen_start_q <= 1'b0;
      case (state)
        SCHED_IDLE: begin
          if (|bus.req) begin
            grant_q     <= arb_gnt;
            rr_ptr      <= arb_idx;
            gen_start_q <= 1'b1;
            state       <= SCHED_START;
          end
        end
        SCHED_START: state <= SCHED_BUSY;
        SCHED_BUSY: begin
          if (bus.gen_done) begin
            grant_q <= '0;
            if (IPG_CYCLES == 0) begin
              state <= SCHED_IDLE;
            end else begin
              gap_cnt <= GAP_W'(IPG_CYCLES - 1);
              state   <= SCHED_GAP;
            end
          end
        end
        SCHED_GAP: begin
          if (gap_cnt == '0) state <= SCHED_IDLE;
          else               gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= SCHED_IDLE;
      endcase
    end
  end

  // Grant is one-hot or zero, so OR-reduction of masked slices is a clean mux.
  always_comb begin
    mux_inclk = 1'b0;
    mux_in    = '0;
    mux_done  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        mux_inclk = mux_inclk | bus.req_inclk[i];
        mux_in    = mux_in | bus.req_in[i*BYTE_LEN +: BYTE_LEN];
        mux_done  = mux_done | bus.req_in_done[i];
      end
    end
  end

  assign bus.grant       = grant_q;
  assign bus.gen_start   = gen_start_q;
  assign bus.gen_inclk   = mux_inclk;
  assign bus.gen_in      = mux_in;
  assign bus.gen_in_done = mux_done;
  assign bus.req_readclk = {NUM_REQ{bus.gen_upstream_readclk}} & grant_q;
  assign bus.req_ack     = {NUM_REQ{done_ok}} & grant_q;
  assign bus.busy        = (state != SCHED_IDLE);

`ifdef ETH_TX_SCHED_STATS_EN
  logic [15:0] wait_cnt [NUM_REQ];
  logic [15:0] wait_max_nxt;

  always_comb begin
    wait_max_nxt = max_wait;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (wait_cnt[i] > wait_max_nxt) wait_max_nxt = wait_cnt[i];
    end
  end

  // Wait counters measure continuous ungranted request time and saturate.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      max_wait  <= '0;
      for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] <= '0;
    end else begin
      if (done_ok) frame_cnt <= frame_cnt + 32'd1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_q[i] || !bus.req[i])   wait_cnt[i] <= '0;
        else if (wait_cnt[i] != 16'hFFFF) wait_cnt[i] <= wait_cnt[i] + 16'd1;
      end
      max_wait <= wait_max_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_eth_tx_scheduler.sv
// Self-checking bench for eth_tx_scheduler: vector table, directed corner sequences, random vs model.
module tb_eth_tx_scheduler;
  import eth_tx_scheduler_pkg::*;

  localparam int N   = 2;
  localparam int IPG = 48;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  eth_tx_scheduler_if #(.NUM_REQ(N)) bus ();

`ifdef ETH_TX_SCHED_STATS_EN
  logic [31:0] frame_cnt;
  logic [15:0] max_wait;
`endif

  eth_tx_scheduler #(
    .NUM_REQ    (N),
    .IPG_CYCLES (IPG)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ETH_TX_SCHED_STATS_EN
    ,
    .frame_cnt (frame_cnt),
    .max_wait  (max_wait)
`endif
  );

  typedef struct {
    logic [1:0]  g;
    logic [1:0]  inclk;
    logic [15:0] din;
    logic [1:0]  idone;
    logic        urd;
    logic        e_inclk;
    logic [7:0]  e_in;
    logic        e_done;
    logic [1:0]  e_rd;
  } vec_t;

  vec_t tv [8];
  int   checks   = 0;
  int   failures = 0;
  int   w;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_payload();
    bus.req_inclk            = '0;
    bus.req_in               = '0;
    bus.req_in_done          = '0;
    bus.gen_upstream_readclk = 1'b0;
  endtask

  task automatic wait_start(input logic [1:0] exp_g, input string tag, output int waited);
    waited = 0;
    while (bus.gen_start !== 1'b1 && waited < 300) begin
      cyc();
      #1;
      waited++;
    end
    chk({tag, "_start"}, 32'(bus.gen_start), 32'd1);
    chk({tag, "_grant"}, 32'(bus.grant), 32'(exp_g));
  endtask

  // Called len cycles before gen_done; ends one cycle into the gap.
  task automatic finish_frame(input logic [1:0] exp_g, input int len, input string tag);
    int extra;
    extra = 0;
    repeat (len - 1) begin
      cyc();
      #1;
      if (bus.gen_start === 1'b1) extra++;
    end
    cyc();
    bus.gen_done = 1'b1;
    #1;
    chk({tag, "_ack"}, 32'(bus.req_ack), 32'(exp_g));
    chk({tag, "_single_start"}, 32'(extra), 32'd0);
    cyc();
    bus.gen_done = 1'b0;
    #1;
    chk({tag, "_gap_grant"}, 32'(bus.grant), 32'd0);
    chk({tag, "_gap_busy"}, 32'(bus.busy), 32'd1);
  endtask

  task automatic apply_tv(input logic [1:0] g);
    for (int e = 0; e < 8; e++) begin
      if (tv[e].g == g) begin
        cyc();
        bus.req_inclk            = tv[e].inclk;
        bus.req_in               = tv[e].din;
        bus.req_in_done          = tv[e].idone;
        bus.gen_upstream_readclk = tv[e].urd;
        #1;
        chk($sformatf("tv%0d_inclk", e), 32'(bus.gen_inclk), 32'(tv[e].e_inclk));
        chk($sformatf("tv%0d_in", e), 32'(bus.gen_in), 32'(tv[e].e_in));
        chk($sformatf("tv%0d_done", e), 32'(bus.gen_in_done), 32'(tv[e].e_done));
        chk($sformatf("tv%0d_rdclk", e), 32'(bus.req_readclk), 32'(tv[e].e_rd));
      end
    end
    clear_payload();
  endtask

  // Reference model state for the random phase: transaction-level bookkeeping only.
  int   last_m, owner, pend_idx, done_at, idle_from;
  bit   infl, pend, exp_start;
  logic [1:0] exp_grant, exp_ack, exp_rd;
  logic       exp_inclk, exp_done;
  logic [7:0] exp_in;

  initial begin
    #700000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '{g:2'b10, inclk:2'b10, din:16'hA53C, idone:2'b00, urd:1'b1, e_inclk:1'b1, e_in:8'hA5, e_done:1'b0, e_rd:2'b10};
    tv[1] = '{g:2'b10, inclk:2'b01, din:16'h00FF, idone:2'b01, urd:1'b0, e_inclk:1'b0, e_in:8'h00, e_done:1'b0, e_rd:2'b00};
    tv[2] = '{g:2'b10, inclk:2'b11, din:16'h5A77, idone:2'b10, urd:1'b1, e_inclk:1'b1, e_in:8'h5A, e_done:1'b1, e_rd:2'b10};
    tv[3] = '{g:2'b10, inclk:2'b00, din:16'hC300, idone:2'b11, urd:1'b0, e_inclk:1'b0, e_in:8'hC3, e_done:1'b1, e_rd:2'b00};
    tv[4] = '{g:2'b01, inclk:2'b01, din:16'hA53C, idone:2'b00, urd:1'b1, e_inclk:1'b1, e_in:8'h3C, e_done:1'b0, e_rd:2'b01};
    tv[5] = '{g:2'b01, inclk:2'b10, din:16'hFF11, idone:2'b10, urd:1'b0, e_inclk:1'b0, e_in:8'h11, e_done:1'b0, e_rd:2'b00};
    tv[6] = '{g:2'b01, inclk:2'b11, din:16'h0099, idone:2'b01, urd:1'b1, e_inclk:1'b1, e_in:8'h99, e_done:1'b1, e_rd:2'b01};
    tv[7] = '{g:2'b01, inclk:2'b00, din:16'h7E00, idone:2'b00, urd:1'b0, e_inclk:1'b0, e_in:8'h00, e_done:1'b0, e_rd:2'b00};

    rst          = 1'b1;
    bus.req      = '0;
    bus.gen_done = 1'b0;
    clear_payload();
    cyc();
    cyc();
    bus.gen_done = 1'b1;
    #1;
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_start", 32'(bus.gen_start), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ack", 32'(bus.req_ack), 32'd0);

    // Single source, then its re-request after the gap.
    cyc();
    bus.gen_done = 1'b0;
    rst          = 1'b0;
    bus.req      = 2'b01;
    #1;
    chk("idle_busy", 32'(bus.busy), 32'd0);
    wait_start(2'b01, "ss", w);
    chk("ss_latency", 32'(w), 32'd1);
    finish_frame(2'b01, 20, "ss");
    wait_start(2'b01, "ss2", w);
    chk("ss_ipg", 32'(w), 32'd49);
    bus.req = 2'b11;
    finish_frame(2'b01, 20, "ss2");

    // Both pending: strict alternation starting with index 1.
    for (int k = 0; k < 4; k++) begin
      logic [1:0] eg;
      eg = (k % 2 == 0) ? 2'b10 : 2'b01;
      wait_start(eg, $sformatf("alt%0d", k), w);
      chk($sformatf("alt%0d_ipg", k), 32'(w), 32'd49);
      finish_frame(eg, 12, $sformatf("alt%0d", k));
    end

    // Payload routing under grant 10, req[1] dropped mid-frame, gen_done in gap ignored.
    wait_start(2'b10, "rt1", w);
    apply_tv(2'b10);
    bus.req = 2'b01;
    cyc();
    #1;
    chk("drop_grant_held", 32'(bus.grant), 32'b10);
    finish_frame(2'b10, 10, "drop");
    cyc();
    bus.gen_done = 1'b1;
    #1;
    chk("gap_done_ack", 32'(bus.req_ack), 32'd0);
    cyc();
    bus.gen_done = 1'b0;
    #1;
    chk("gap_done_busy", 32'(bus.busy), 32'd1);
    wait_start(2'b01, "rt0", w);
    chk("gap_done_ignored_ipg", 32'(w), 32'd47);
    apply_tv(2'b01);
    finish_frame(2'b01, 10, "rt0");

    // Reset during BUSY.
    bus.req = 2'b11;
    wait_start(2'b10, "rb", w);
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    rst          = 1'b0;
    bus.gen_done = 1'b1;
    #1;
    chk("rb_grant", 32'(bus.grant), 32'd0);
    chk("rb_start", 32'(bus.gen_start), 32'd0);
    chk("rb_busy", 32'(bus.busy), 32'd0);
    chk("rb_ack", 32'(bus.req_ack), 32'd0);
    bus.gen_done = 1'b0;
    wait_start(2'b10, "rb_post", w);
    chk("rb_post_latency", 32'(w), 32'd1);
    finish_frame(2'b10, 10, "rb");

    // Reset during GAP; rotation pointer must restart.
    cyc();
    rst = 1'b1;
    cyc();
    rst          = 1'b0;
    bus.gen_done = 1'b1;
    #1;
    chk("rg_grant", 32'(bus.grant), 32'd0);
    chk("rg_start", 32'(bus.gen_start), 32'd0);
    chk("rg_busy", 32'(bus.busy), 32'd0);
    chk("rg_ack", 32'(bus.req_ack), 32'd0);
    bus.gen_done = 1'b0;
    wait_start(2'b10, "rg_post", w);
    chk("rg_post_latency", 32'(w), 32'd1);
    finish_frame(2'b10, 10, "rg");

`ifdef ETH_TX_SCHED_STATS_EN
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("st_frame_cnt_rst", frame_cnt, 32'd0);
    chk("st_max_wait_rst", 32'(max_wait), 32'd0);
    bus.req = 2'b11;
    wait_start(2'b10, "st1", w);
    finish_frame(2'b10, 30, "st1");
    wait_start(2'b01, "st2", w);
    finish_frame(2'b01, 10, "st2");
    wait_start(2'b10, "st3", w);
    finish_frame(2'b10, 10, "st3");
    chk("st_frame_cnt", frame_cnt, 32'd3);
    chk("st_max_wait_ge70", 32'(max_wait >= 16'd70), 32'd1);
`endif

    // Random traffic against the transaction-level model.
    rst          = 1'b1;
    bus.req      = '0;
    bus.gen_done = 1'b0;
    clear_payload();
    cyc();
    cyc();
    rst       = 1'b0;
    last_m    = 0;
    infl      = 1'b0;
    pend      = 1'b0;
    idle_from = 0;
    owner     = 0;
    pend_idx  = 0;
    done_at   = 0;
    for (int n = 1; n <= 2500; n++) begin
      cyc();
      exp_start = pend;
      if (pend) begin
        infl    = 1'b1;
        owner   = pend_idx;
        done_at = n + int'($urandom_range(1, 25));
        pend    = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) bus.req = 2'($urandom_range(0, 3));
      bus.req_inclk            = 2'($urandom_range(0, 3));
      bus.req_in               = 16'($urandom);
      bus.req_in_done          = 2'($urandom_range(0, 3));
      bus.gen_upstream_readclk = 1'($urandom_range(0, 1));
      bus.gen_done             = infl ? (n == done_at) : ($urandom_range(0, 15) == 0);
      #1;
      exp_grant = infl ? 2'(1 << owner) : 2'b00;
      exp_ack   = (infl && bus.gen_done) ? exp_grant : 2'b00;
      exp_rd    = bus.gen_upstream_readclk ? exp_grant : 2'b00;
      exp_inclk = infl ? bus.req_inclk[owner] : 1'b0;
      exp_done  = infl ? bus.req_in_done[owner] : 1'b0;
      exp_in    = infl ? bus.req_in[owner*8 +: 8] : 8'h00;
      chk($sformatf("rnd_grant@%0d", n), 32'(bus.grant), 32'(exp_grant));
      chk($sformatf("rnd_start@%0d", n), 32'(bus.gen_start), 32'(exp_start));
      chk($sformatf("rnd_ack@%0d", n), 32'(bus.req_ack), 32'(exp_ack));
      chk($sformatf("rnd_busy@%0d", n), 32'(bus.busy), 32'(infl || pend || n < idle_from));
      chk($sformatf("rnd_rdclk@%0d", n), 32'(bus.req_readclk), 32'(exp_rd));
      chk($sformatf("rnd_inclk@%0d", n), 32'(bus.gen_inclk), 32'(exp_inclk));
      chk($sformatf("rnd_in@%0d", n), 32'(bus.gen_in), 32'(exp_in));
      chk($sformatf("rnd_indone@%0d", n), 32'(bus.gen_in_done), 32'(exp_done));
      if (infl && bus.gen_done) begin
        infl      = 1'b0;
        idle_from = n + IPG + 1;
      end else if (!infl && n >= idle_from && bus.req != 2'b00) begin
        bit found;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          int j;
          j = (last_m + k) % N;
          if (!found && bus.req[j]) begin
            found    = 1'b1;
            pend_idx = j;
          end
        end
        pend   = 1'b1;
        last_m = pend_idx;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eth_tx_scheduler.md
Name: eth_tx_scheduler

Overview:
- Sequences eth_frame_generator and shares it between NUM_REQ payload sources.
- Arbitrates round-robin among pending frame requests and issues a single-cycle start.
- While a frame is in flight, muxes the granted source's payload stream into the generator and routes the generator's upstream_readclk back to that source only.
- Enforces the Ethernet inter-packet gap after every frame's done.

Parameters:
- NUM_REQ, 2, number of payload requesters (at least 1).
- IPG_CYCLES, 48, idle clocks after generator done before the next start; 96 bit times at one dibit per clock.

Ports:
- clk  in  1  system clock (RMII-rate dibit clock domain).
- rst  in  1  reset, synchronous, active-high.
- req  in  NUM_REQ  per-source frame-pending level.
- req_inclk  in  NUM_REQ  per-source payload byte strobe.
- req_in  in  NUM_REQ*BYTE_LEN  per-source payload bytes; source i occupies slice [i*BYTE_LEN +: BYTE_LEN].
- req_in_done  in  NUM_REQ  per-source end-of-payload flag.
- req_readclk  out  NUM_REQ  payload read request, routed to the granted source.
- req_ack  out  NUM_REQ  one-cycle pulse to the granted source when its frame completes.
- grant  out  NUM_REQ  one-hot grant, registered.
- gen_start  out  1  start pulse to the generator.
- gen_inclk  out  1  muxed payload strobe to the generator.
- gen_in  out  BYTE_LEN  muxed payload byte to the generator.
- gen_in_done  out  1  muxed payload done flag to the generator.
- gen_upstream_readclk  in  1  generator's payload read request.
- gen_done  in  1  generator end-of-CRC pulse.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - state IDLE, grant 0, gen_start 0, req_ack 0.
  - rr_ptr 0: the last-served index, so the first search starts at index 1 mod NUM_REQ.
  - gap counter 0.
- Muxing (combinational from the registered grant):
  - gen_inclk, gen_in and gen_in_done come from the granted slice; all are 0 when grant is 0.
  - req_readclk[i] = gen_upstream_readclk && grant[i].
- IDLE:
  - If req is non-zero, select the first set bit searching from rr_ptr+1 upward, wrapping modulo NUM_REQ.
  - Register grant one-hot, set rr_ptr to the selected index, go to START.
  - Latency: req sampled high at edge t gives grant at t+1 and gen_start high during cycle t+1.
- START:
  - gen_start = 1 for exactly this one cycle; go to BUSY.
- BUSY:
  - Hold grant and ignore req changes, including deassertion of the granted req.
  - On gen_done: pulse req_ack for the granted source in the same cycle (combinational from gen_done and grant).
  - At that edge: clear grant, load gap counter with IPG_CYCLES-1, go to GAP.
- GAP:
  - Decrement the counter each cycle; at 0 go to IDLE.
  - IDLE arbitrates the next cycle, so gen_done to next gen_start is at least IPG_CYCLES+2 clocks.
  - IPG_CYCLES = 0 is legal: skip GAP and go BUSY to IDLE.
- Simultaneous requests:
  - Strict rotation; a source that keeps req high cannot be served twice while another is pending.
- Boundary cases:
  - gen_done outside BUSY is ignored.
  - req_inclk from non-granted sources is dropped.
  - rst in any state returns to IDLE the next edge with all outputs zero.
  - The generator shares rst, so an in-flight frame is abandoned without a req_ack.
- Width rules:
  - rr_ptr is clog2(NUM_REQ) bits wide, minimum 1.
  - The gap counter is clog2(IPG_CYCLES+1) bits wide.

Optional Feature:
- Macro: ETH_TX_SCHED_STATS_EN.
- When defined:
  - Adds output frame_cnt (32 bits, reset 0), incremented on each accepted gen_done in BUSY and wrapping at 2^32.
  - Adds output max_wait (16 bits, reset 0): the longest number of cycles any req bit was high while not granted, saturating at 0xFFFF.
  - Adds one 16-bit wait counter per requester, cleared on grant.
- When undefined: these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- Shared params.vh supplies BYTE_LEN and clog2.
- Shared package additions:
  - state encodings SCHED_IDLE=0, SCHED_START=1, SCHED_BUSY=2, SCHED_GAP=3;
  - ETH_IPG_DIBITS=48, used as the IPG_CYCLES default.
- One natural sub-module: rr_arbiter. Inputs: req, ptr. Outputs: one-hot gnt and index. It is purely combinational, so it is reusable and unit-testable.

Test Plan:
- Single source: req=01, generator model returns gen_done 20 cycles after start -> grant=01 one cycle after req, single gen_start, req_ack[0] coincident with gen_done, next start no earlier than 50 cycles after gen_done.
- Both sources high continuously -> grants alternate 10,01,10,01 starting with index 1; each frame is followed by a 48-cycle gap with busy high.
- Payload routing: under grant=10, pulse gen_upstream_readclk -> only req_readclk[1] pulses; byte 0xA5 on source 1 appears on gen_in; source 0 strobes produce no gen_inclk.
- req[1] drops mid-BUSY -> grant held, frame completes, req_ack[1] pulses; gen_done injected during GAP is ignored.
- rst asserted in BUSY and in GAP -> next cycle state IDLE, grant=0, gen_start=0, no req_ack; the first post-reset arbitration with req=11 grants index 1.
- With ETH_TX_SCHED_STATS_EN: 3 frames -> frame_cnt=3; source 0 held 70 cycles behind source 1's frame -> max_wait of at least 70.
